uart_cmd_bridge: RTL and testbench

UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

---
 rtl/uart_bridge_pkg.sv | 22 ++
 rtl/uart_cmd_bridge.sv | 149 ++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_bridge_pkg.sv
// Shared types and byte codes for the UART command bridge.
// Holds the FSM state encoding and the command and reply bytes used on the wire.
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
        ST_BUS_WR,
        ST_BUS_RD,
        ST_RD_WAIT,
        ST_SEND
    } state_t;

    localparam logic [7:0] CMD_WR = 8'h57;  // 'W'
    localparam logic [7:0] CMD_RD = 8'h52;  // 'R'
    localparam logic [7:0] RSP_OK = 8'h4B;  // 'K'
    localparam logic [7:0] RSP_ERR = 8'h3F; // '?'

    localparam int unsigned CNT_W = 24;

endpackage

// File: rtl/uart_cmd_bridge.sv
// Turns byte frames from an RX FIFO ('W' addr data / 'R' addr) into register-bus
// accesses and pushes a one-byte reply ('K', read data or '?') into a TX FIFO.
module uart_cmd_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_empty,
    input  logic [7:0] rx_rd_data,
    output logic       rx_rd_en,
    input  logic       tx_full,
    output logic       tx_wr_en,
    output logic [7:0] tx_wr_data,
    output logic [7:0] reg_addr,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_data,
    output logic       reg_rd_en,
    input  logic [7:0] reg_rd_data,
    output logic       busy,
    output logic       frame_err
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic               is_rd_q, is_rd_d;
    logic [7:0]         addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;
    logic [7:0]         reply_q, reply_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic in_frame;
    logic timeout;
    logic byte_ok;

    assign in_frame = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);
    assign timeout  = in_frame && (cnt_q == TO_LAST);
    // Gating with reset_n keeps the pop strobe quiet while reset is held.
    assign byte_ok  = reset_n && !rx_empty;

    // NOTE: every output and next-state value gets a default before the case so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        is_rd_d   = is_rd_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        reply_d   = reply_q;
        rx_rd_en  = 1'b0;
        tx_wr_en  = 1'b0;
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        frame_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (byte_ok) begin
                    rx_rd_en = 1'b1;
                    if (rx_rd_data == CMD_WR) begin
                        is_rd_d = 1'b0;
                        state_d = ST_GET_ADDR;
                    end else if (rx_rd_data == CMD_RD) begin
                        is_rd_d = 1'b1;
                        state_d = ST_GET_ADDR;
                    end else begin
                        reply_d   = RSP_ERR;
                        frame_err = 1'b1;
                        state_d   = ST_SEND;
                    end
                end
            end
            ST_GET_ADDR: begin
                // Timeout wins over a byte arriving the same cycle; that byte restarts from IDLE.
                if (timeout) begin
                    frame_err = 1'b1;
                    state_d   = ST_IDLE;
                end else if (byte_ok) begin
                    rx_rd_en = 1'b1;
                    addr_d   = rx_rd_data;
                    state_d  = is_rd_q ? ST_BUS_RD : ST_GET_DATA;
                end
            end
            ST_GET_DATA: begin
                if (timeout) begin
                    frame_err = 1'b1;
                    state_d   = ST_IDLE;
                end else if (byte_ok) begin
                    rx_rd_en = 1'b1;
                    wdata_d  = rx_rd_data;
                    state_d  = ST_BUS_WR;
                end
            end
            ST_BUS_WR: begin
                reg_wr_en = 1'b1;
                reply_d   = RSP_OK;
                state_d   = ST_SEND;
            end
            ST_BUS_RD: begin
                reg_rd_en = 1'b1;
                state_d   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                reply_d = reg_rd_data;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_full) begin
                    tx_wr_en = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Inter-byte timer: restarts on each byte or state change, saturates at the abort point.
        cnt_d = cnt_q;
        if (!in_frame || rx_rd_en || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (rx_empty && (cnt_q != TO_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            is_rd_q <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            reply_q <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            is_rd_q <= is_rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            reply_q <= reply_d;
            cnt_q   <= cnt_d;
        end
    end

    assign tx_wr_data  = reply_q;
    assign reg_addr    = addr_q;
    assign reg_wr_data = wdata_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Directed bench for uart_cmd_bridge: a small RX FIFO model feeds frames and
// monitors count strobes, pushes and error pulses against hand-computed values.
module tb_uart_cmd_bridge;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx_empty;
    logic [7:0] rx_rd_data;
    logic       rx_rd_en;
    logic       tx_full = 1'b0;
    logic       tx_wr_en;
    logic [7:0] tx_wr_data;
    logic [7:0] reg_addr;
    logic       reg_wr_en;
    logic [7:0] reg_wr_data;
    logic       reg_rd_en;
    logic [7:0] reg_rd_data = 8'h00;
    logic       busy;
    logic       frame_err;

    uart_cmd_bridge #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_empty    (rx_empty),
        .rx_rd_data  (rx_rd_data),
        .rx_rd_en    (rx_rd_en),
        .tx_full     (tx_full),
        .tx_wr_en    (tx_wr_en),
        .tx_wr_data  (tx_wr_data),
        .reg_addr    (reg_addr),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_data (reg_wr_data),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (reg_rd_data),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // RX FIFO model, first-word fall-through
    logic [7:0] rx_mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    assign rx_empty   = (wr_ptr == rd_ptr);
    assign rx_rd_data = rx_mem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (rx_rd_en && !rx_empty) rd_ptr <= rd_ptr + 1;
    end

    // register read data arrives one cycle after the strobe
    logic [7:0] rd_value = 8'h00;
    always @(posedge clk) begin
        if (reg_rd_en) reg_rd_data <= rd_value;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_wr, n_rd, n_tx, n_err, n_pop, n_viol;
    int wr_cyc, rd_cyc, tx_cyc, err_cyc, pop_cyc;
    logic [7:0] wr_addr, wr_data, rd_addr, tx_last;

    always @(negedge clk) begin
        if (reg_wr_en) begin
            n_wr++; wr_addr = reg_addr; wr_data = reg_wr_data; wr_cyc = cyc;
        end
        if (reg_rd_en) begin
            n_rd++; rd_addr = reg_addr; rd_cyc = cyc;
        end
        if (tx_wr_en) begin
            n_tx++; tx_last = tx_wr_data; tx_cyc = cyc;
        end
        if (frame_err) begin
            n_err++; err_cyc = cyc;
        end
        if (rx_rd_en) begin
            n_pop++; pop_cyc = cyc;
        end
        if ((reg_wr_en && reg_rd_en) || (rx_rd_en && rx_empty)) n_viol++;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic clear_counts();
        @(posedge clk);
        #1;
        n_wr = 0; n_rd = 0; n_tx = 0; n_err = 0; n_pop = 0; n_viol = 0;
        wr_cyc = 0; rd_cyc = 0; tx_cyc = 0; err_cyc = 0; pop_cyc = 0;
        wr_addr = 0; wr_data = 0; rd_addr = 0; tx_last = 0;
        @(negedge clk);
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int n = 0;
        @(negedge clk);
        while (n < budget && !(busy == 1'b0 && rx_empty)) begin
            @(negedge clk);
            n++;
        end
        check(tag, (n < budget), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs",
              {rx_rd_en, tx_wr_en, reg_wr_en, reg_rd_en, busy, frame_err,
               tx_wr_data, reg_addr, reg_wr_data}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // write frame
        clear_counts();
        push(8'h57); push(8'h10); push(8'hA5);
        wait_quiet("wr_done", 50);
        check("wr_count", n_wr, 1);
        check("wr_addr", wr_addr, 8'h10);
        check("wr_data", wr_data, 8'hA5);
        check("wr_strobe_lat", wr_cyc - pop_cyc, 1);
        check("wr_tx_count", n_tx, 1);
        check("wr_tx_data", tx_last, 8'h4B);
        check("wr_tx_lat", tx_cyc - wr_cyc, 1);
        check("wr_no_rd", n_rd, 0);

        // read frame
        clear_counts();
        rd_value = 8'h3C;
        push(8'h52); push(8'h22);
        wait_quiet("rd_done", 50);
        check("rd_count", n_rd, 1);
        check("rd_addr", rd_addr, 8'h22);
        check("rd_tx_data", tx_last, 8'h3C);
        check("rd_tx_lat", tx_cyc - rd_cyc, 2);
        check("rd_no_wr", n_wr, 0);

        // unknown command
        clear_counts();
        push(8'h41);
        wait_quiet("unk_done", 50);
        check("unk_tx_count", n_tx, 1);
        check("unk_tx_data", tx_last, 8'h3F);
        check("unk_err", n_err, 1);
        check("unk_no_bus", n_wr + n_rd, 0);

        // timeout mid-frame, then a normal read
        clear_counts();
        push(8'h57); push(8'h10);
        wait_quiet("tmo_done", 60);
        check("tmo_err", n_err, 1);
        check("tmo_err_cycle", err_cyc - pop_cyc, 16);
        check("tmo_no_bus", n_wr + n_rd, 0);
        check("tmo_no_tx", n_tx, 0);
        clear_counts();
        rd_value = 8'h77;
        push(8'h52); push(8'h05);
        wait_quiet("tmo_rd_done", 50);
        check("tmo_rd_count", n_rd, 1);
        check("tmo_rd_addr", rd_addr, 8'h05);
        check("tmo_rd_tx", tx_last, 8'h77);
        check("tmo_rd_err", n_err, 0);

        // back-pressure in SEND with a frame queued behind
        clear_counts();
        tx_full = 1'b1;
        push(8'h41); push(8'h57); push(8'h33); push(8'h44);
        repeat (12) @(negedge clk);
        check("bp_no_tx", n_tx, 0);
        check("bp_one_pop", n_pop, 1);
        check("bp_busy", busy, 1'b1);
        tx_full = 1'b0;
        wait_quiet("bp_done", 60);
        check("bp_tx_count", n_tx, 2);
        check("bp_tx_last", tx_last, 8'h4B);
        check("bp_wr_count", n_wr, 1);
        check("bp_wr_addr", wr_addr, 8'h33);
        check("bp_wr_data", wr_data, 8'h44);
        check("bp_err", n_err, 1);

        // reset mid-frame
        clear_counts();
        push(8'h57); push(8'h10);
        repeat (4) @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              {rx_rd_en, tx_wr_en, reg_wr_en, reg_rd_en, busy, frame_err,
               tx_wr_data, reg_addr, reg_wr_data}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        clear_counts();
        repeat (20) @(negedge clk);
        check("rst_no_activity", n_wr + n_rd + n_tx + n_err, 0);
        push(8'h57); push(8'h01); push(8'hFF);
        wait_quiet("rst_wr_done", 50);
        check("rst_wr_count", n_wr, 1);
        check("rst_wr_addr", wr_addr, 8'h01);
        check("rst_wr_data", wr_data, 8'hFF);
        check("rst_tx_count", n_tx, 1);
        check("rst_tx_data", tx_last, 8'h4B);
        check("rst_viol", n_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
